// File: rtl/timer_n.sv
// timer_n: hours/minutes/seconds countdown or count-up timer driven by a 1 Hz tick.
// Values are entered with debounced pulses, stored as a preset when the run starts,
// and an alarm phase of ALARM_SECS cycles follows reaching the end point.
// The outputs come straight from the state and display registers, so they change
// only on clk_1Hz edges or on reset.
module timer_n #(
  parameter int MAX_HOURS  = 12,
  parameter int HOUR_W     = 5,
  parameter int ALARM_SECS = 5,
  parameter int RELOAD     = 0
) (
  input  logic              clk_1Hz,
  input  logic              resetn,
  input  logic              mode_in,
  input  logic              start_stop,
  input  logic              dir_up,
  input  logic              hour_in,
  input  logic              min_in,
  input  logic              sec_in,
  output logic [HOUR_W-1:0] hour_out,
  output logic [5:0]        min_out,
  output logic [5:0]        sec_out,
  output logic              running,
  output logic              alarm
);

  // A single alarm cycle still needs a one-bit counter.
  localparam int CNT_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [HOUR_W-1:0] MAX_H      = HOUR_W'(MAX_HOURS);
  localparam logic [CNT_W-1:0]  ALARM_LAST = CNT_W'(ALARM_SECS - 1);
  localparam logic [5:0]        LAST_MS    = 6'd59;

  typedef enum logic [2:0] {S_IDLE, S_INPUT, S_RUN, S_PAUSE, S_ALARM} state_t;

  state_t            state_reg, state_next;
  logic [HOUR_W-1:0] hour_reg, hour_next, pre_h_reg, pre_h_next;
  logic [5:0]        min_reg, min_next, pre_m_reg, pre_m_next;
  logic [5:0]        sec_reg, sec_next, pre_s_reg, pre_s_next;
  logic              dir_reg, dir_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // Candidate values for the set phase and for one run tick.
  logic [HOUR_W-1:0] set_h, tick_h;
  logic [5:0]        set_m, set_s, tick_m, tick_s;
  logic              cap, disp_zero, at_end;

  // Set-phase increments: hour wraps past MAX_H, and a capped hour pins min/sec at zero.
  always_comb begin
    set_h = hour_reg;
    if (hour_in) set_h = (hour_reg == MAX_H) ? '0 : hour_reg + 1'b1;
    cap   = (hour_reg == MAX_H) || (set_h == MAX_H);
    set_m = min_reg;
    if (min_in) set_m = (min_reg == LAST_MS) ? '0 : min_reg + 1'b1;
    set_s = sec_reg;
    if (sec_in) set_s = (sec_reg == LAST_MS) ? '0 : sec_reg + 1'b1;
    if (cap) begin
      set_m = '0;
      set_s = '0;
    end
  end

  // One run tick in the latched direction, plus the end-point test on the result.
  always_comb begin
    tick_h = hour_reg;
    tick_m = min_reg;
    tick_s = sec_reg;
    if (!dir_reg) begin
      if (sec_reg != '0) begin
        tick_s = sec_reg - 1'b1;
      end else begin
        tick_s = LAST_MS;
        if (min_reg != '0) begin
          tick_m = min_reg - 1'b1;
        end else begin
          tick_m = LAST_MS;
          tick_h = hour_reg - 1'b1;
        end
      end
    end else begin
      if (sec_reg != LAST_MS) begin
        tick_s = sec_reg + 1'b1;
      end else begin
        tick_s = '0;
        if (min_reg != LAST_MS) begin
          tick_m = min_reg + 1'b1;
        end else begin
          tick_m = '0;
          tick_h = hour_reg + 1'b1;
        end
      end
    end
    disp_zero = (hour_reg == '0) && (min_reg == '0) && (sec_reg == '0);
    if (dir_reg)
      at_end = (tick_h == pre_h_reg) && (tick_m == pre_m_reg) && (tick_s == pre_s_reg);
    else
      at_end = (tick_h == '0) && (tick_m == '0) && (tick_s == '0);
  end

  // State and datapath registers.
  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      hour_reg  <= '0;
      min_reg   <= '0;
      sec_reg   <= '0;
      pre_h_reg <= '0;
      pre_m_reg <= '0;
      pre_s_reg <= '0;
      dir_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hour_reg  <= hour_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
      pre_h_reg <= pre_h_next;
      pre_m_reg <= pre_m_next;
      pre_s_reg <= pre_s_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state and next datapath values; mode_in low overrides everything.
  always_comb begin
    state_next = state_reg;
    hour_next  = hour_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    pre_h_next = pre_h_reg;
    pre_m_next = pre_m_reg;
    pre_s_next = pre_s_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    if (!mode_in) begin
      state_next = S_IDLE;
      hour_next  = '0;
      min_next   = '0;
      sec_next   = '0;
      pre_h_next = '0;
      pre_m_next = '0;
      pre_s_next = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_INPUT;
        S_INPUT: begin
          if (start_stop) begin
            // A zero display cannot start; pulses are ignored while start_stop is high.
            if (!disp_zero) begin
              state_next = S_RUN;
              pre_h_next = hour_reg;
              pre_m_next = min_reg;
              pre_s_next = sec_reg;
              dir_next   = dir_up;
              if (dir_up) begin
                hour_next = '0;
                min_next  = '0;
                sec_next  = '0;
              end
            end
          end else begin
            hour_next = set_h;
            min_next  = set_m;
            sec_next  = set_s;
          end
        end
        S_RUN: begin
          if (!start_stop) begin
            state_next = S_PAUSE;
          end else begin
            hour_next = tick_h;
            min_next  = tick_m;
            sec_next  = tick_s;
            if (at_end) begin
              state_next = S_ALARM;
              cnt_next   = ALARM_LAST;
            end
          end
        end
        S_PAUSE: if (start_stop) state_next = S_RUN;
        S_ALARM: begin
          if (cnt_reg == '0) begin
            if ((RELOAD != 0) && start_stop) begin
              state_next = S_RUN;
              hour_next  = dir_reg ? '0 : pre_h_reg;
              min_next   = dir_reg ? '0 : pre_m_reg;
              sec_next   = dir_reg ? '0 : pre_s_reg;
            end else begin
              state_next = S_INPUT;
              hour_next  = pre_h_reg;
              min_next   = pre_m_reg;
              sec_next   = pre_s_reg;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state and display.
  always_comb begin
    running  = (state_reg == S_RUN);
    alarm    = (state_reg == S_ALARM);
    hour_out = hour_reg;
    min_out  = min_reg;
    sec_out  = sec_reg;
  end

endmodule

// File: tb/tb_timer_n.sv
// Directed testbench for timer_n: a default instance and a RELOAD=1 instance
// share the same stimulus; expected values are hand-computed.
module tb_timer_n;

  logic       clk_1Hz = 1'b0;
  logic       resetn = 1'b1;
  logic       mode_in = 1'b0, start_stop = 1'b0, dir_up = 1'b0;
  logic       hour_in = 1'b0, min_in = 1'b0, sec_in = 1'b0;
  logic [4:0] hour_out, hour_out_rl;
  logic [5:0] min_out, sec_out, min_out_rl, sec_out_rl;
  logic       running, alarm, running_rl, alarm_rl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  timer_n #(.MAX_HOURS(12), .HOUR_W(5), .ALARM_SECS(5), .RELOAD(0)) dut (
    .clk_1Hz(clk_1Hz), .resetn(resetn), .mode_in(mode_in), .start_stop(start_stop),
    .dir_up(dir_up), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_out(hour_out), .min_out(min_out), .sec_out(sec_out),
    .running(running), .alarm(alarm)
  );

  timer_n #(.MAX_HOURS(12), .HOUR_W(5), .ALARM_SECS(5), .RELOAD(1)) dut_rl (
    .clk_1Hz(clk_1Hz), .resetn(resetn), .mode_in(mode_in), .start_stop(start_stop),
    .dir_up(dir_up), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_out(hour_out_rl), .min_out(min_out_rl), .sec_out(sec_out_rl),
    .running(running_rl), .alarm(alarm_rl)
  );

  function automatic int hms(input int h, input int m, input int s);
    return h * 10000 + m * 100 + s;
  endfunction

  function automatic int disp();
    return hms(int'(hour_out), int'(min_out), int'(sec_out));
  endfunction

  function automatic int disp_rl();
    return hms(int'(hour_out_rl), int'(min_out_rl), int'(sec_out_rl));
  endfunction

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock edge; inputs are driven and outputs sampled 1 unit after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1Hz);
      #1;
    end
  endtask

  // Clear through IDLE and land in INPUT with a zero display.
  task automatic clear_to_input();
    mode_in = 1'b0; start_stop = 1'b0; dir_up = 1'b0;
    hour_in = 1'b0; min_in = 1'b0; sec_in = 1'b0;
    step();
    mode_in = 1'b1;
    step();
    check_eq("clear_disp", disp(), 0);
  endtask

  initial begin
    // Asynchronous reset
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_disp", disp(), 0);
    check_eq("rst_running", int'(running), 0);
    check_eq("rst_alarm", int'(alarm), 0);
    step();
    check_eq("rst_hold_disp", disp(), 0);
    resetn = 1'b1;

    // Test 1: countdown from 0:00:02, alarm phase, back to INPUT with preset
    $display("test1: countdown 0:00:02");
    mode_in = 1'b1;
    step();
    sec_in = 1'b1;
    step(2);
    sec_in = 1'b0;
    check_eq("t1_set", disp(), hms(0, 0, 2));
    start_stop = 1'b1;
    step();
    check_eq("t1_run_entry", disp(), hms(0, 0, 2));
    check_eq("t1_running", int'(running), 1);
    step();
    check_eq("t1_tick1", disp(), hms(0, 0, 1));
    step();
    check_eq("t1_tick0", disp(), 0);
    check_eq("t1_alarm_on", int'(alarm), 1);
    check_eq("t1_run_off", int'(running), 0);
    start_stop = 1'b0;
    step(4);
    check_eq("t1_alarm_5th", int'(alarm), 1);
    check_eq("t1_alarm_disp", disp(), 0);
    step();
    check_eq("t1_alarm_off", int'(alarm), 0);
    check_eq("t1_back_preset", disp(), hms(0, 0, 2));
    check_eq("t1_not_running", int'(running), 0);

    // Test 2: 1:00:00 countdown with pause and resume
    $display("test2: pause/resume");
    clear_to_input();
    hour_in = 1'b1;
    step();
    hour_in = 1'b0;
    check_eq("t2_set", disp(), hms(1, 0, 0));
    start_stop = 1'b1;
    step(2);
    check_eq("t2_first_tick", disp(), hms(0, 59, 59));
    start_stop = 1'b0;
    step(3);
    check_eq("t2_frozen", disp(), hms(0, 59, 59));
    check_eq("t2_paused", int'(running), 0);
    start_stop = 1'b1;
    step();
    check_eq("t2_resume_edge", disp(), hms(0, 59, 59));
    check_eq("t2_resume_run", int'(running), 1);
    step();
    check_eq("t2_resume_tick", disp(), hms(0, 59, 58));

    // Test 3: hour cap and wrap at MAX_HOURS
    $display("test3: hour cap");
    clear_to_input();
    min_in = 1'b1;
    step(30);
    min_in = 1'b0;
    check_eq("t3_min30", disp(), hms(0, 30, 0));
    hour_in = 1'b1;
    step(11);
    check_eq("t3_h11", disp(), hms(11, 30, 0));
    min_in = 1'b1; sec_in = 1'b1;
    step();
    check_eq("t3_h12_cap", disp(), hms(12, 0, 0));
    hour_in = 1'b0;
    step();
    check_eq("t3_ms_ignored", disp(), hms(12, 0, 0));
    min_in = 1'b0; sec_in = 1'b0; hour_in = 1'b1;
    step();
    hour_in = 1'b0;
    check_eq("t3_wrap", disp(), 0);

    // Test 4: count-up to 0:01:02
    $display("test4: count-up");
    clear_to_input();
    min_in = 1'b1;
    step();
    min_in = 1'b0; sec_in = 1'b1;
    step(2);
    sec_in = 1'b0;
    check_eq("t4_set", disp(), hms(0, 1, 2));
    dir_up = 1'b1; start_stop = 1'b1;
    step();
    check_eq("t4_start_zero", disp(), 0);
    step();
    check_eq("t4_one", disp(), hms(0, 0, 1));
    step(58);
    check_eq("t4_59", disp(), hms(0, 0, 59));
    step();
    check_eq("t4_carry", disp(), hms(0, 1, 0));
    check_eq("t4_no_alarm", int'(alarm), 0);
    step(2);
    check_eq("t4_end", disp(), hms(0, 1, 2));
    check_eq("t4_alarm", int'(alarm), 1);
    start_stop = 1'b0; dir_up = 1'b0;
    step(4);
    check_eq("t4_alarm_last", int'(alarm), 1);
    step();
    check_eq("t4_alarm_done", int'(alarm), 0);
    check_eq("t4_preset", disp(), hms(0, 1, 2));

    // Test 5: auto-reload instance restarts, default instance returns to INPUT
    $display("test5: reload");
    clear_to_input();
    sec_in = 1'b1;
    step(3);
    sec_in = 1'b0;
    start_stop = 1'b1;
    step(4);
    check_eq("t5_rl_alarm", int'(alarm_rl), 1);
    check_eq("t5_rl_zero", disp_rl(), 0);
    step(4);
    check_eq("t5_rl_alarm_last", int'(alarm_rl), 1);
    step();
    check_eq("t5_rl_alarm_off", int'(alarm_rl), 0);
    check_eq("t5_rl_running", int'(running_rl), 1);
    check_eq("t5_rl_reload", disp_rl(), hms(0, 0, 3));
    check_eq("t5_norl_running", int'(running), 0);
    check_eq("t5_norl_preset", disp(), hms(0, 0, 3));
    step();
    check_eq("t5_rl_tick", disp_rl(), hms(0, 0, 2));

    // Test 6: mode_in drop during RUN, reset during ALARM
    $display("test6: abort paths");
    clear_to_input();
    min_in = 1'b1;
    step();
    min_in = 1'b0;
    start_stop = 1'b1;
    step(21);
    check_eq("t6_at40", disp(), hms(0, 0, 40));
    mode_in = 1'b0;
    step();
    check_eq("t6_mode_disp", disp(), 0);
    check_eq("t6_mode_run", int'(running), 0);
    check_eq("t6_mode_alarm", int'(alarm), 0);
    start_stop = 1'b0; mode_in = 1'b1;
    step();
    sec_in = 1'b1;
    step(2);
    sec_in = 1'b0; start_stop = 1'b1;
    step(4);
    check_eq("t6_in_alarm", int'(alarm), 1);
    resetn = 1'b0;
    #1;
    check_eq("t6_rst_alarm", int'(alarm), 0);
    check_eq("t6_rst_disp", disp(), 0);
    check_eq("t6_rst_run", int'(running), 0);
    step();
    resetn = 1'b1;
    step();
    check_eq("t6_post_alarm", int'(alarm), 0);
    check_eq("t6_post_run", int'(running), 0);
    check_eq("t6_post_disp", disp(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
